dzcpu_useq: RTL and testbench

DZCPU_USEQ -- requirements
Module: dzcpu_useq

---
 rtl/dzcpu_useq_pkg.sv | 22 ++
 rtl/dzcpu_useq.sv | 161 ++++++++++++++++
 tb/tb_dzcpu_useq.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dzcpu_useq_pkg.sv
// Shared definitions for the dzcpu micro-sequencer:
// uop control codes and sequencer state encodings.
package dzcpu_useq_pkg;

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_DECODE   = 2'd1,
    S_CBDECODE = 2'd2,
    S_EXEC     = 2'd3
  } state_t;

  localparam logic [3:0] CTL_OP         = 4'd0;
  localparam logic [3:0] CTL_INC        = 4'd1;
  localparam logic [3:0] CTL_EOF        = 4'd2;
  localparam logic [3:0] CTL_INC_EOF    = 4'd3;
  localparam logic [3:0] CTL_EOF_FU     = 4'd4;
  localparam logic [3:0] CTL_INC_EOF_FU = 4'd5;
  localparam logic [3:0] CTL_INC_EOF_Z  = 4'd6;
  localparam logic [3:0] CTL_JCB        = 4'd7;
  localparam logic [3:0] CTL_NOP        = 4'd8;

endpackage

// File: rtl/dzcpu_useq.sv
// dzcpu micro-sequencer: fetch, decode, uop execution.
// Define DZCPU_USEQ_CB_EN to enable the CB-prefix (jcb) path.
module dzcpu_useq
  import dzcpu_useq_pkg::*;
(
  input  logic       iClock,
  input  logic       iReset,
  input  logic [7:0] iMemData,
  input  logic       iMemBusy,
  input  logic [7:0] iFlowIdx,
  input  logic [7:0] iCbFlowIdx,
  input  logic [3:0] iUopCtl,
  input  logic       iZFlag,
  output logic [7:0] oUopAddr,
  output logic       oUopValid,
  output logic       oPcInc,
  output logic       oFlagUpdate,
  output logic [7:0] oMop,
  output logic [7:0] oCbMop,
  output logic       oEof,
  output logic       oError
);

  state_t     r_state;
  state_t     w_nxt_state;
  logic [7:0] r_upc;
  logic [7:0] w_nxt_upc;
  logic [7:0] r_mop;
  logic       r_err;
  logic       w_ld_mop;
  logic       w_valid;
  logic       w_pc;
  logic       w_fu;
  logic       w_end;
  logic       w_err;
  logic       w_step;
`ifdef DZCPU_USEQ_CB_EN
  logic [7:0] r_cbmop;
  logic       w_ld_cb;
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_upc   = r_upc;
    w_ld_mop    = 1'b0;
    w_valid     = 1'b0;
    w_pc        = 1'b0;
    w_fu        = 1'b0;
    w_end       = 1'b0;
    w_err       = 1'b0;
    w_step      = 1'b0;
`ifdef DZCPU_USEQ_CB_EN
    w_ld_cb     = 1'b0;
`endif
    unique case (r_state)
      S_FETCH: begin
        if (!iMemBusy) begin
          w_ld_mop    = 1'b1;
          w_nxt_state = S_DECODE;
        end
      end
      S_DECODE: begin
        w_nxt_upc   = iFlowIdx;
        w_nxt_state = S_EXEC;
      end
`ifdef DZCPU_USEQ_CB_EN
      S_CBDECODE: begin
        w_nxt_upc   = iCbFlowIdx;
        w_nxt_state = S_EXEC;
      end
`endif
      S_EXEC: begin
        if (!iMemBusy) begin
          w_valid = 1'b1;
          unique case (1'b1)
            (iUopCtl == CTL_OP) ||
            (iUopCtl == CTL_NOP): w_step = 1'b1;
            iUopCtl == CTL_INC: begin
              w_pc   = 1'b1;
              w_step = 1'b1;
            end
            iUopCtl == CTL_EOF: w_end = 1'b1;
            iUopCtl == CTL_INC_EOF: begin
              w_pc  = 1'b1;
              w_end = 1'b1;
            end
            iUopCtl == CTL_EOF_FU: begin
              w_fu  = 1'b1;
              w_end = 1'b1;
            end
            iUopCtl == CTL_INC_EOF_FU: begin
              w_pc  = 1'b1;
              w_fu  = 1'b1;
              w_end = 1'b1;
            end
            iUopCtl == CTL_INC_EOF_Z: begin
              w_pc   = iZFlag;
              w_end  = iZFlag;
              w_step = !iZFlag;
            end
`ifdef DZCPU_USEQ_CB_EN
            iUopCtl == CTL_JCB: begin
              w_pc        = 1'b1;
              w_ld_cb     = 1'b1;
              w_nxt_state = S_CBDECODE;
            end
`endif
            default: begin
              w_end = 1'b1;
              w_err = 1'b1;
            end
          endcase
          // Stepping past the last ROM word is a fault, not a wrap.
          if (w_step && r_upc == 8'hFF) begin
            w_end = 1'b1;
            w_err = 1'b1;
          end else if (w_step) begin
            w_nxt_upc = r_upc + 8'd1;
          end
          if (w_end) w_nxt_state = S_FETCH;
        end
      end
      default: w_nxt_state = S_FETCH;
    endcase
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_state <= S_FETCH;
      r_upc   <= 8'd0;
      r_mop   <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_upc   <= w_nxt_upc;
      if (w_ld_mop) r_mop <= iMemData;
      if (w_err) r_err <= 1'b1;
    end
  end

`ifdef DZCPU_USEQ_CB_EN
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) r_cbmop <= 8'd0;
    else if (w_ld_cb) r_cbmop <= iMemData;
  end
  assign oCbMop = r_cbmop;
`else
  logic w_unused_cb;
  assign w_unused_cb = ^iCbFlowIdx;
  assign oCbMop      = 8'd0;
`endif

  assign oUopAddr    = r_upc;
  assign oUopValid   = w_valid;
  assign oPcInc      = w_pc;
  assign oFlagUpdate = w_fu;
  assign oEof        = w_end;
  assign oMop        = r_mop;
  assign oError      = r_err;

endmodule

// File: tb/tb_dzcpu_useq.sv
// Testbench for dzcpu_useq: directed scenarios plus
// randomized flows against an instruction-level model.
module tb_dzcpu_useq;

  localparam int PH_FE = 0;
  localparam int PH_DE = 1;
  localparam int PH_CB = 2;
  localparam int PH_EX = 3;
`ifdef DZCPU_USEQ_CB_EN
  localparam bit CB_EN = 1'b1;
`else
  localparam bit CB_EN = 1'b0;
`endif

  logic       iClock = 1'b0;
  logic       iReset = 1'b0;
  logic       iMemBusy = 1'b1;
  logic       iZFlag = 1'b0;
  logic [7:0] iMemData = 8'd0;
  logic [7:0] iFlowIdx, iCbFlowIdx;
  logic [3:0] iUopCtl;
  logic [7:0] oUopAddr, oMop, oCbMop;
  logic       oUopValid, oPcInc, oFlagUpdate, oEof, oError;

  logic [3:0] rom   [256];
  logic [7:0] lut   [256];
  logic [7:0] cblut [256];

  assign iUopCtl    = rom[oUopAddr];
  assign iFlowIdx   = lut[oMop];
  assign iCbFlowIdx = cblut[oCbMop];

  logic [11:0] w_obs;
  assign w_obs = {oUopAddr, oUopValid, oPcInc, oFlagUpdate, oEof};

  int checks = 0;
  int errors = 0;

  dzcpu_useq dut (
    .iClock(iClock), .iReset(iReset), .iMemData(iMemData),
    .iMemBusy(iMemBusy), .iFlowIdx(iFlowIdx),
    .iCbFlowIdx(iCbFlowIdx), .iUopCtl(iUopCtl), .iZFlag(iZFlag),
    .oUopAddr(oUopAddr), .oUopValid(oUopValid), .oPcInc(oPcInc),
    .oFlagUpdate(oFlagUpdate), .oMop(oMop), .oCbMop(oCbMop),
    .oEof(oEof), .oError(oError)
  );

  always #5 iClock = ~iClock;

  task automatic clear_mem;
    for (int i = 0; i < 256; i++) begin
      rom[i] = 4'd8; lut[i] = 8'd0; cblut[i] = 8'd0;
    end
  endtask

  task automatic tick(input logic b, input logic [7:0] d, input logic z);
    @(negedge iClock);
    iMemBusy = b; iMemData = d; iZFlag = z;
    #1;
  endtask

  task automatic do_reset;
    iMemBusy = 1'b1;
    iReset = 1'b0;
    #3;
    @(negedge iClock);
    iReset = 1'b1;
  endtask

  task automatic start(input logic [7:0] op);
    tick(1'b0, op, 1'b0);
    tick(1'b0, 8'd0, 1'b0);
  endtask

  task automatic test_reset;
    iReset = 1'b0;
    #1;
    checks++;
    if ({w_obs, oMop, oCbMop, oError} !== 29'd0) begin
      errors++;
      $display("FAIL reset_state: got %h/%h/%h/%b want 0",
               w_obs, oMop, oCbMop, oError);
    end
    @(negedge iClock);
    iReset = 1'b1;
    tick(1'b1, 8'hAB, 1'b0);
    checks++;
    if ({oMop, w_obs} !== 20'd0) begin
      errors++;
      $display("FAIL fetch_hold: got %h %h want 0", oMop, w_obs);
    end
    tick(1'b0, 8'hAB, 1'b0);
    tick(1'b1, 8'h00, 1'b0);
    checks++;
    if (oMop !== 8'hAB || oUopValid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_load: got mop %h v %b want ab 0",
               oMop, oUopValid);
    end
  endtask

  task automatic test_flow;
    logic [11:0] e;
    do_reset();
    lut[8'h3A] = 8'd5;
    rom[5] = 4'd1; rom[6] = 4'd1; rom[7] = 4'd0; rom[8] = 4'd3;
    start(8'h3A);
    checks++;
    if (oMop !== 8'h3A || oUopValid !== 1'b0) begin
      errors++;
      $display("FAIL flow_decode: got mop %h want 3a", oMop);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 8'd0, 1'b0);
      e = {8'(5 + i), 1'b1, i != 2, 1'b0, i == 3};
      checks++;
      if (w_obs !== e) begin
        errors++;
        $display("FAIL flow_uop%0d: got %h want %h", i, w_obs, e);
      end
    end
    tick(1'b1, 8'd0, 1'b0);
    checks++;
    if (w_obs !== {8'd8, 4'b0000}) begin
      errors++;
      $display("FAIL flow_back_fetch: got %h want 080", w_obs);
    end
  endtask

  task automatic test_zflag;
    do_reset();
    lut[8'h11] = 8'd19;
    rom[19] = 4'd6; rom[20] = 4'd2;
    start(8'h11);
    tick(1'b0, 8'd0, 1'b1);
    checks++;
    if (w_obs !== {8'd19, 4'b1101}) begin
      errors++;
      $display("FAIL z1_pulse: got %h want 13d", w_obs);
    end
    tick(1'b1, 8'd0, 1'b0);
    checks++;
    if (w_obs !== {8'd19, 4'b0000}) begin
      errors++;
      $display("FAIL z1_fetch: got %h want 130", w_obs);
    end
    start(8'h11);
    tick(1'b0, 8'd0, 1'b0);
    checks++;
    if (w_obs !== {8'd19, 4'b1000}) begin
      errors++;
      $display("FAIL z0_nopulse: got %h want 138", w_obs);
    end
    tick(1'b0, 8'd0, 1'b0);
    checks++;
    if (w_obs !== {8'd20, 4'b1001}) begin
      errors++;
      $display("FAIL z0_next: got %h want 149", w_obs);
    end
  endtask

  task automatic test_cb;
    do_reset();
    lut[8'hCB] = 8'd30;
    rom[30] = 4'd7;
    cblut[8'h7C] = 8'd16;
    rom[16] = 4'd3;
    start(8'hCB);
    tick(1'b0, 8'h7C, 1'b0);
`ifdef DZCPU_USEQ_CB_EN
    checks++;
    if (w_obs !== {8'd30, 4'b1100}) begin
      errors++;
      $display("FAIL cb_jcb: got %h want 1ec", w_obs);
    end
    tick(1'b1, 8'd0, 1'b0);
    checks++;
    if (oCbMop !== 8'h7C || w_obs !== {8'd30, 4'b0000}) begin
      errors++;
      $display("FAIL cb_latch: got %h %h want 7c 1e0", oCbMop, w_obs);
    end
    tick(1'b0, 8'd0, 1'b0);
    checks++;
    if (w_obs !== {8'd16, 4'b1101} || oError !== 1'b0) begin
      errors++;
      $display("FAIL cb_exec: got %h err %b want 10d 0", w_obs, oError);
    end
`else
    checks++;
    if (w_obs !== {8'd30, 4'b1001}) begin
      errors++;
      $display("FAIL cb_illegal: got %h want 1e9", w_obs);
    end
    tick(1'b1, 8'd0, 1'b0);
    checks++;
    if (oError !== 1'b1 || oCbMop !== 8'd0 || w_obs[3:0] !== 4'd0) begin
      errors++;
      $display("FAIL cb_err: got err %b cb %h obs %h want 1 00 x0",
               oError, oCbMop, w_obs);
    end
`endif
  endtask

  task automatic test_busy;
    do_reset();
    lut[8'h44] = 8'd40;
    rom[40] = 4'd1; rom[41] = 4'd2;
    start(8'h44);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 8'd0, 1'b0);
      checks++;
      if (w_obs !== {8'd40, 4'b0000}) begin
        errors++;
        $display("FAIL busy_hold%0d: got %h want 280", i, w_obs);
      end
    end
    tick(1'b0, 8'd0, 1'b0);
    checks++;
    if (w_obs !== {8'd40, 4'b1100}) begin
      errors++;
      $display("FAIL busy_resume: got %h want 28c", w_obs);
    end
    tick(1'b0, 8'd0, 1'b0);
    checks++;
    if (w_obs !== {8'd41, 4'b1001}) begin
      errors++;
      $display("FAIL busy_next: got %h want 299", w_obs);
    end
  endtask

  task automatic test_illegal;
    do_reset();
    lut[8'h55] = 8'd60;
    rom[60] = 4'hF;
    start(8'h55);
    tick(1'b0, 8'd0, 1'b0);
    checks++;
    if (w_obs !== {8'd60, 4'b1001} || oError !== 1'b0) begin
      errors++;
      $display("FAIL ill_eof: got %h err %b want 3c9 0", w_obs, oError);
    end
    tick(1'b1, 8'd0, 1'b0);
    checks++;
    if (oError !== 1'b1 || oUopValid !== 1'b0) begin
      errors++;
      $display("FAIL ill_err: got %b want 1", oError);
    end
    do_reset();
    checks++;
    if (oError !== 1'b0) begin
      errors++;
      $display("FAIL ill_clear: got %b want 0", oError);
    end
    lut[8'h66] = 8'hFF;
    rom[255] = 4'd0;
    start(8'h66);
    tick(1'b0, 8'd0, 1'b0);
    checks++;
    if (w_obs !== {8'hFF, 4'b1001}) begin
      errors++;
      $display("FAIL wrap_eof: got %h want ff9", w_obs);
    end
    tick(1'b1, 8'd0, 1'b0);
    checks++;
    if (oError !== 1'b1 || w_obs !== {8'hFF, 4'b0000}) begin
      errors++;
      $display("FAIL wrap_err: got %b %h want 1 ff0", oError, w_obs);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    lut[8'h77] = 8'd52;
    rom[52] = 4'd8; rom[53] = 4'd8;
    start(8'h77);
    tick(1'b0, 8'd0, 1'b0);
    checks++;
    if (w_obs !== {8'd52, 4'b1000}) begin
      errors++;
      $display("FAIL ar_exec: got %h want 348", w_obs);
    end
    #2 iReset = 1'b0;
    #1;
    checks++;
    if ({w_obs, oMop, oCbMop, oError} !== 29'd0) begin
      errors++;
      $display("FAIL ar_clear: got %h %h %h %b want 0",
               w_obs, oMop, oCbMop, oError);
    end
    iMemBusy = 1'b1;
    @(negedge iClock);
    iReset = 1'b1;
    tick(1'b0, 8'h77, 1'b0);
    checks++;
    if (w_obs !== 12'd0 || oMop !== 8'd0) begin
      errors++;
      $display("FAIL ar_fetch: got %h %h want 0", w_obs, oMop);
    end
    tick(1'b0, 8'd0, 1'b0);
    tick(1'b0, 8'd0, 1'b0);
    checks++;
    if (w_obs !== {8'd52, 4'b1000} || oMop !== 8'h77) begin
      errors++;
      $display("FAIL ar_restart: got %h %h want 348 77", w_obs, oMop);
    end
  endtask

  task automatic test_random;
    int         m_ph;
    logic [7:0] m_upc, m_mop, m_cb;
    logic       m_err;
    logic [3:0] c;
    logic       b, z, v, pc, fu, en, adv, bad, gocb;
    logic [7:0] d;
    logic [28:0] e, o;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      rom[i]   = ($urandom_range(0, 19) == 0) ? 4'hA
                                              : 4'($urandom_range(0, 8));
      lut[i]   = 8'($urandom);
      cblut[i] = 8'($urandom);
    end
    m_ph = PH_FE; m_upc = 8'd0; m_mop = 8'd0; m_cb = 8'd0; m_err = 1'b0;
    for (int n = 0; n < 800; n++) begin
      b = ($urandom_range(0, 3) == 0);
      d = 8'($urandom);
      z = 1'($urandom_range(0, 1));
      tick(b, d, z);
      c = rom[m_upc];
      pc = 0; fu = 0; en = 0; adv = 0; bad = 0; gocb = 0;
      case (c)
        4'd0, 4'd8: adv = 1;
        4'd1: begin pc = 1; adv = 1; end
        4'd2: en = 1;
        4'd3: begin pc = 1; en = 1; end
        4'd4: begin fu = 1; en = 1; end
        4'd5: begin pc = 1; fu = 1; en = 1; end
        4'd6: if (z) begin pc = 1; en = 1; end else adv = 1;
        4'd7: if (CB_EN) begin pc = 1; gocb = 1; end
              else begin bad = 1; en = 1; end
        default: begin bad = 1; en = 1; end
      endcase
      if (adv && m_upc == 8'hFF) begin bad = 1; en = 1; end
      v = (m_ph == PH_EX) && !b;
      e = {m_upc, v, v & pc, v & fu, v & en, m_mop, m_cb, m_err};
      o = {w_obs, oMop, oCbMop, oError};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rand_cyc%0d: got %h want %h", n, o, e);
      end
      case (m_ph)
        PH_FE: if (!b) begin m_mop = d; m_ph = PH_DE; end
        PH_DE: begin m_upc = lut[m_mop]; m_ph = PH_EX; end
        PH_CB: begin m_upc = cblut[m_cb]; m_ph = PH_EX; end
        default: if (!b) begin
          if (bad) m_err = 1;
          if (gocb) begin m_cb = d; m_ph = PH_CB; end
          else if (en) m_ph = PH_FE;
          else m_upc = m_upc + 8'd1;
        end
      endcase
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_flow();
    test_zflag();
    test_cb();
    test_busy();
    test_illegal();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
